// File: rtl/microprocessor_pkg.sv
// Shared definitions for the processor top level: loader state encoding,
// frame sync byte and instruction width.
package microprocessor_pkg;

    localparam int         INSTR_W   = 32;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/byte_timeout.sv
// Idle counter between received bytes; expired pulses on the cycle the count
// would reach TIMEOUT_CYCLES, unless a byte clears it in that same cycle.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && !clear && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader for instruction memory: assembles big-endian words,
// writes them from address 0 and holds the CPU until the checksum verifies.
module program_loader
    import microprocessor_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               byteValid,
    input  logic [7:0]         byteData,
    output logic               byteReady,
    output logic               imemWrite,
    output logic [ADDR_W-1:0]  imemAddress,
    output logic [INSTR_W-1:0] imemWriteData,
    output logic               cpuHold,
    output logic               loadDone,
    output logic               loadError,
    output loader_state_t      debug_state
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    // A byte moves only when byteValid and byteReady are both high on a rising
    // edge; byteReady stays high whenever out of reset, so there is no stall.
    logic accept;
    logic is_sync;
    logic expired;
    logic timer_enable;
    logic word_last;

    loader_state_t          state;
    loader_state_t          state_next;
    logic [7:0]             len_hi;
    logic [15:0]            words_left;
    logic [ADDR_W-1:0]      word_addr;
    logic [1:0]             byte_idx;
    logic [INSTR_W-9:0]     assembly;
    logic [7:0]             csum;
    logic [15:0]            length;

    assign accept       = byteValid && byteReady;
    assign is_sync      = (byteData == SYNC_BYTE);
    assign word_last    = (byte_idx == 2'd3);
    assign length       = {len_hi, byteData};
    assign timer_enable = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                          (state == ST_DATA)   || (state == ST_CHECK);

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .resetN (resetN),
        .clear  (accept),
        .enable (timer_enable),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept && is_sync) state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept)       state_next = ST_LEN_LO;
                else if (expired) state_next = ST_ERROR;
            end
            ST_LEN_LO: begin
                if (accept) begin
                    if (length == 16'd0)                state_next = ST_CHECK;
                    else if ({1'b0, length} > MAX_WORDS) state_next = ST_ERROR;
                    else                                state_next = ST_DATA;
                end else if (expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (word_last && words_left == 16'd1) state_next = ST_CHECK;
                end else if (expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_CHECK: begin
                if (accept)       state_next = (byteData == csum) ? ST_DONE : ST_ERROR;
                else if (expired) state_next = ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (accept && is_sync) state_next = ST_LEN_HI;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            byteReady     <= 1'b0;
            imemWrite     <= 1'b0;
            imemAddress   <= '0;
            imemWriteData <= '0;
            len_hi        <= '0;
            words_left    <= '0;
            word_addr     <= '0;
            byte_idx      <= '0;
            assembly      <= '0;
            csum          <= '0;
        end else begin
            byteReady <= 1'b1;
            imemWrite <= 1'b0;
            if (accept) begin
                unique case (state)
                    ST_IDLE, ST_DONE, ST_ERROR: begin
                        if (is_sync) begin
                            csum      <= '0;
                            word_addr <= '0;
                            byte_idx  <= '0;
                        end
                    end
                    ST_LEN_HI: len_hi <= byteData;
                    ST_LEN_LO: words_left <= length;
                    ST_DATA: begin
                        assembly <= {assembly[INSTR_W-17:0], byteData};
                        csum     <= csum ^ byteData;
                        byte_idx <= byte_idx + 2'd1;
                        // Address and data registers only change with a new strobe.
                        if (word_last) begin
                            imemWrite     <= 1'b1;
                            imemAddress   <= word_addr;
                            imemWriteData <= {assembly, byteData};
                            word_addr     <= word_addr + ADDR_W'(1);
                            words_left    <= words_left - 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cpuHold     = (state != ST_DONE);
    assign loadDone    = (state == ST_DONE);
    assign loadError   = (state == ST_ERROR);
    assign debug_state = state;

endmodule
